// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
// Holds FSM states, dm_size codes, byte-enable patterns, MAX_WAIT default.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_BUSY = 2'd1,
    ST_DM_BUSY = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_WORD2 = 2'b11;

  // Bit 3 is byte 0 (big-endian lane order).
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b1000;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  localparam int MAX_WAIT_DEF = 16;

endpackage

// File: rtl/mem_lane_align.sv
// Data-port lane alignment: byte enables, write-data replication, misalign.
// Ports: size/addr_lo/wdata in; be, wdata_rep, misalign out (combinational).
module mem_lane_align
  import mem_port_arbiter_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign
);

  always_comb begin
    be        = BE_WORD;
    wdata_rep = wdata;
    misalign  = 1'b0;
    unique case (size)
      SZ_BYTE: begin
        be        = BE_BYTE0 >> addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = addr_lo[1] ? BE_HALF_LO : BE_HALF_HI;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = addr_lo[0];
      end
      default: begin
        misalign  = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM-stage requests onto one shared memory port.
// Ports: clk/reset, if_* fetch port, dm_* data port, mem_* memory, stalls.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        dm_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          if_lost_q, if_lost_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic [31:0]   dm_rdata_q, dm_rdata_d;

  logic [3:0]    dm_be;
  logic [31:0]   dm_wrep;
  logic          dm_mis;

  logic is_if, is_dm, busy, arb;
  logic timeout, done, dm_win, if_win, dm_bad;
  logic unused_addr_lo;

  mem_lane_align u_align (
    .size      (dm_size),
    .addr_lo   (dm_addr[1:0]),
    .wdata     (dm_wdata),
    .be        (dm_be),
    .wdata_rep (dm_wrep),
    .misalign  (dm_mis)
  );

  assign unused_addr_lo = ^if_addr[1:0];

  assign is_if   = (state_q == ST_IF_BUSY);
  assign is_dm   = (state_q == ST_DM_BUSY);
  assign busy    = is_if | is_dm;
  assign timeout = busy & (wait_q == CW'(MAX_WAIT));
  assign done    = busy & ~timeout & mem_ack;

  // No arbitration while reset is held, so nothing pulses during reset.
  assign arb    = (state_q == ST_IDLE) & ~reset;
  assign dm_win = arb & dm_req & (~if_req | ~if_lost_q);
  assign if_win = arb & if_req & ~dm_win;
  assign dm_bad = dm_win & dm_mis;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dm_win & ~dm_mis) state_d = ST_DM_BUSY;
        else if (if_win)      state_d = ST_IF_BUSY;
      end
      ST_IF_BUSY, ST_DM_BUSY: begin
        if (timeout | mem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wait_d     = wait_q;
    if_lost_d  = if_lost_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    if (!busy || timeout || mem_ack) wait_d = '0;
    else                             wait_d = wait_q + 1'b1;

    if (if_win)               if_lost_d = 1'b0;
    else if (dm_win & if_req) if_lost_d = 1'b1;

    if (if_win) begin
      addr_d  = {if_addr[31:2], 2'b00};
      wdata_d = '0;
      be_d    = BE_WORD;
      we_d    = 1'b0;
    end else if (dm_win) begin
      addr_d  = {dm_addr[31:2], 2'b00};
      wdata_d = dm_wrep;
      be_d    = dm_be;
      we_d    = dm_we;
    end

    if (is_if & done)    if_rdata_d = mem_rdata;
    if (is_if & timeout) if_rdata_d = '0;
    if (is_dm & done)    dm_rdata_d = mem_rdata;
    if (is_dm & timeout) dm_rdata_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_q     <= '0;
      if_lost_q  <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= BE_NONE;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      wait_q     <= wait_d;
      if_lost_q  <= if_lost_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  // Completion-cycle rdata bypasses the register; timeout shows zero.
  always_comb begin
    mem_req   = busy & ~timeout;
    mem_we    = mem_req & we_q;
    mem_be    = mem_req ? be_q : BE_NONE;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if_ready  = is_if & (done | timeout);
    if_err    = is_if & timeout;
    dm_ready  = (is_dm & (done | timeout)) | dm_bad;
    dm_err    = (is_dm & timeout) | dm_bad;
    if_rdata  = if_ready ? if_rdata_d : if_rdata_q;
    dm_rdata  = (is_dm & (done | timeout)) ? dm_rdata_d : dm_rdata_q;
    stall_if  = if_req & ~if_ready;
    stall_mem = dm_req & ~dm_ready;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scoreboard bench for mem_port_arbiter.
// Drives both ports and a scripted memory; checks with immediate asserts.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready, if_err;
  logic        dm_req, dm_we;
  logic [1:0]  dm_size;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_ready, dm_err;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall_if, stall_mem;

  typedef struct packed {
    logic        dm;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_dm;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .if_err    (if_err),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_size   (dm_size),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .dm_err    (dm_err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .stall_if  (stall_if),
    .stall_mem (stall_mem)
  );

  function automatic exp_t mk(input logic dm, input logic [31:0] rd,
                              input logic err);
    exp_t e;
    e.dm  = dm;
    e.rd  = rd;
    e.err = err;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_port"}, 32'({dm_ready, if_ready}),
          e.dm ? 32'd2 : 32'd1);
      chk({tag, "_rdata"}, e.dm ? dm_rdata : if_rdata, e.rd);
      chk({tag, "_err"}, 32'(e.dm ? dm_err : if_err), 32'(e.err));
    end
  endtask

  task automatic wait_mem_req(input string tag);
    int n = 0;
    while (mem_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_memreq"}, 32'(mem_req), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (!(if_ready === 1'b1 || dm_ready === 1'b1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    pop_check(tag);
  endtask

  task automatic complete(input string tag, input int dly,
                          input logic [31:0] rd);
    repeat (dly) @(posedge clk);
    #1;
    mem_ack   = 1'b1;
    mem_rdata = rd;
    wait_done(tag);
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
  endtask

  task automatic dm_access(input string tag, input logic we,
                           input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] ea,
                           input logic [3:0] ebe, input logic [31:0] ewd,
                           input logic [31:0] rd);
    dm_req   = 1'b1;
    dm_we    = we;
    dm_size  = sz;
    dm_addr  = a;
    dm_wdata = wd;
    sb.push_back(mk(1'b1, rd, 1'b0));
    wait_mem_req(tag);
    chk({tag, "_addr"}, mem_addr, ea);
    chk({tag, "_be"}, 32'(mem_be), 32'(ebe));
    chk({tag, "_wdata"}, mem_wdata, ewd);
    chk({tag, "_we"}, 32'(mem_we), 32'(we));
    @(posedge clk);
    #1;
    dm_addr  = ~a;
    dm_wdata = ~wd;
    dm_we    = ~we;
    @(negedge clk);
    chk({tag, "_hold"}, {mem_addr[31:1], mem_we}, {ea[31:1], we});
    complete(tag, 1, rd);
    dm_req  = 1'b0;
    last_dm = rd;
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_size   = 2'b00;
    dm_addr   = '0;
    dm_wdata  = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    last_dm   = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_memreq", 32'(mem_req), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_rdy", 32'({if_ready, dm_ready, if_err, dm_err}), 32'd0);
    chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // single fetch, ack two cycles after mem_req
    if_req  = 1'b1;
    if_addr = 32'h100;
    sb.push_back(mk(1'b0, 32'hDEADBEEF, 1'b0));
    @(negedge clk);
    chk("f_idle_req", 32'(mem_req), 32'd0);
    chk("f_stall_idle", 32'(stall_if), 32'd1);
    wait_mem_req("f");
    chk("f_addr", mem_addr, 32'h100);
    chk("f_be", 32'(mem_be), 32'hF);
    chk("f_stall_busy", 32'(stall_if), 32'd1);
    complete("f", 2, 32'hDEADBEEF);
    if_req = 1'b0;
    @(negedge clk);
    chk("f_hold", if_rdata, 32'hDEADBEEF);
    chk("f_stall_after", 32'(stall_if), 32'd0);
    chk("f_after_req", 32'(mem_req), 32'd0);

    // ack in IDLE ignored, then minimum latency
    @(posedge clk);
    #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h11112222;
    @(negedge clk);
    chk("ackidle_rdy", 32'({if_ready, dm_ready}), 32'd0);
    chk("ackidle_req", 32'(mem_req), 32'd0);
    @(posedge clk);
    #1;
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_size = 2'b10;
    dm_addr = 32'h404;
    sb.push_back(mk(1'b1, 32'h11112222, 1'b0));
    @(negedge clk);
    chk("lat_n_rdy", 32'(dm_ready), 32'd0);
    chk("lat_stall", 32'(stall_mem), 32'd1);
    @(negedge clk);
    chk("lat_n1_req", 32'(mem_req), 32'd1);
    chk("lat_addr", mem_addr, 32'h404);
    pop_check("lat");
    chk("lat_if_hold", if_rdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    dm_req    = 1'b0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    last_dm   = 32'h11112222;

    // lane alignment table
    dm_access("bs", 1'b1, 2'b00, 32'h203, 32'h000000A5,
              32'h200, 4'b0001, 32'hA5A5A5A5, 32'hCAFE0001);
    dm_access("hs", 1'b1, 2'b01, 32'h206, 32'hBEEF1234,
              32'h204, 4'b0011, 32'h12341234, 32'hCAFE0002);
    dm_access("bl", 1'b0, 2'b00, 32'h201, 32'h0000005A,
              32'h200, 4'b0100, 32'h5A5A5A5A, 32'hCAFE0003);
    dm_access("hl", 1'b0, 2'b01, 32'h204, 32'h00005678,
              32'h204, 4'b1100, 32'h56785678, 32'hCAFE0004);
    dm_access("w3", 1'b1, 2'b11, 32'h208, 32'h89ABCDEF,
              32'h208, 4'b1111, 32'h89ABCDEF, 32'hCAFE0005);

    // misaligned word and half
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_size = 2'b10;
    dm_addr = 32'h202;
    sb.push_back(mk(1'b1, last_dm, 1'b1));
    @(negedge clk);
    chk("misw_req", 32'(mem_req), 32'd0);
    pop_check("misw");
    chk("misw_stall", 32'(stall_mem), 32'd0);
    @(posedge clk);
    #1;
    dm_size = 2'b01;
    dm_addr = 32'h205;
    sb.push_back(mk(1'b1, last_dm, 1'b1));
    @(negedge clk);
    chk("mish_req", 32'(mem_req), 32'd0);
    pop_check("mish");
    @(posedge clk);
    #1 dm_req = 1'b0;
    @(negedge clk);
    chk("mis_after_req", 32'(mem_req), 32'd0);
    chk("mis_after_rdy", 32'(dm_ready), 32'd0);

    // contention: DM first, then IF wins on fairness, then DM
    @(posedge clk);
    #1;
    if_req  = 1'b1;
    if_addr = 32'h700;
    dm_req  = 1'b1;
    dm_size = 2'b10;
    dm_addr = 32'h500;
    sb.push_back(mk(1'b1, 32'h0A0A0A0A, 1'b0));
    sb.push_back(mk(1'b0, 32'h0B0B0B0B, 1'b0));
    wait_mem_req("c1");
    chk("c1_addr", mem_addr, 32'h500);
    chk("c1_stall_if", 32'(stall_if), 32'd1);
    complete("c1", 1, 32'h0A0A0A0A);
    dm_addr = 32'h600;
    sb.push_back(mk(1'b1, 32'h0C0C0C0C, 1'b0));
    wait_mem_req("c2");
    chk("c2_addr", mem_addr, 32'h700);
    chk("c2_stall_mem", 32'(stall_mem), 32'd1);
    complete("c2", 2, 32'h0B0B0B0B);
    if_req = 1'b0;
    wait_mem_req("c3");
    chk("c3_addr", mem_addr, 32'h600);
    complete("c3", 1, 32'h0C0C0C0C);
    dm_req  = 1'b0;
    last_dm = 32'h0C0C0C0C;

    // timeout after MAX_WAIT unacknowledged cycles
    dm_req  = 1'b1;
    dm_size = 2'b10;
    dm_addr = 32'h300;
    sb.push_back(mk(1'b1, 32'h0, 1'b1));
    wait_mem_req("to");
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("to_cycles", 32'(n), 32'd16);
    pop_check("to");
    @(posedge clk);
    #1 dm_req = 1'b0;
    @(negedge clk);
    chk("to_rdata_reg", dm_rdata, 32'h0);
    chk("to_after_req", 32'(mem_req), 32'd0);

    // reset mid-access, then a late ack
    @(posedge clk);
    #1;
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_addr  = 32'h800;
    dm_wdata = 32'h55AA55AA;
    wait_mem_req("rs");
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("rs_req", 32'({mem_req, mem_we}), 32'd0);
    chk("rs_be", 32'(mem_be), 32'd0);
    chk("rs_rdy", 32'({if_ready, dm_ready, if_err, dm_err}), 32'd0);
    chk("rs_rdata", if_rdata | dm_rdata, 32'd0);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    dm_req    = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h77777777;
    @(negedge clk);
    chk("rs_late_rdy", 32'({if_ready, dm_ready}), 32'd0);
    chk("rs_late_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("rs_late2", 32'({if_ready, dm_ready, mem_req}), 32'd0);
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if_req    = 1'b1;
    if_addr   = 32'h900;
    sb.push_back(mk(1'b0, 32'h12345678, 1'b0));
    wait_mem_req("pr");
    chk("pr_addr", mem_addr, 32'h900);
    complete("pr", 1, 32'h12345678);
    if_req = 1'b0;

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, default 16, meaning cycles mem_req may stay unacknowledged before the access is aborted.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 if_req  in  1  fetch request, held until if_ready.
REQ-005 if_addr  in  32  fetch word address.
REQ-006 if_rdata  out  32  fetch data.
REQ-007 if_ready  out  1  one-cycle fetch completion pulse.
REQ-008 if_err  out  1  fetch timeout flag, valid with if_ready.
REQ-009 dm_req  in  1  data request from the MEM stage, held until dm_ready.
REQ-010 dm_we  in  1  1 = store, 0 = load.
REQ-011 dm_size  in  2  00 = byte, 01 = half, 10 = word; 11 is treated as word.
REQ-012 dm_addr  in  32  data byte address.
REQ-013 dm_wdata  in  32  store data, right-justified.
REQ-014 dm_rdata  out  32  load data, raw word.
REQ-015 dm_ready  out  1  one-cycle data completion pulse.
REQ-016 dm_err  out  1  misalign or timeout flag, valid with dm_ready.
REQ-017 mem_req, mem_we  out  1 each  shared memory request and write strobe.
REQ-018 mem_addr, mem_wdata  out  32 each  word-aligned address and lane-replicated data.
REQ-019 mem_be  out  4  byte enables; bit 3 is byte 0, the MSB lane (big-endian).
REQ-020 mem_ack, mem_rdata  in  1 / 32  memory completion and read data.
REQ-021 stall_if, stall_mem  out  1 each  pipeline stall requests.

Function
REQ-022 FSM states: IDLE, IF_BUSY, DM_BUSY.
- Commands are latched on entry to a BUSY state.
- mem_req is asserted in every BUSY cycle and is low in IDLE.
REQ-023 Arbitration happens in IDLE only.
- dm_req alone wins; if_req alone wins.
- When both are asserted, DM wins unless fairness flag if_lost=1, in which case IF wins.
REQ-024 if_lost update:
- Set when IF requested and lost arbitration.
- Cleared when IF is granted.
REQ-025 On mem_ack in a BUSY state:
- The served port's ready pulses in the same cycle.
- Its rdata equals mem_rdata in that cycle; the registered copy holds that value until that port's next completion.
- The next state is IDLE.
REQ-026 Minimum latency: request seen in IDLE at cycle N, mem_req at N+1, earliest ready at N+1.
REQ-027 Wait counter:
- Clears on BUSY entry and increments each unacknowledged BUSY cycle.
- At MAX_WAIT it drops mem_req, pulses ready with err=1, zeroes that port's rdata register, and returns to IDLE.
REQ-028 mem_be:
- Byte: 4'b1000 >> addr[1:0].
- Half: addr[1]=0 gives 1100, addr[1]=1 gives 0011.
- Word: 1111.
- Fetch: 1111.
REQ-029 mem_wdata: byte replicated 4x, half replicated 2x, word unchanged.
REQ-030 mem_addr = {addr[31:2], 2'b00}.
REQ-031 A DM request with half and addr[0]=1, or word and addr[1:0]!=0, is misaligned.
- It is not issued to memory.
- It pulses dm_ready and dm_err in the IDLE cycle in which it wins arbitration.
- FSM stays in IDLE and if_lost updates as for a grant.
REQ-032 mem_ack in IDLE is ignored and has no effect.
REQ-033 Stall outputs: stall_if = if_req & ~if_ready; stall_mem = dm_req & ~dm_ready (combinational).
REQ-034 Command inputs may change while BUSY without affecting the access in flight.

Reset
REQ-035 Reset asserted at any time, including mid-access, forces the following immediately:
- IDLE state.
- mem_req=0, mem_we=0, mem_be=0.
- Both ready and err outputs 0.
- rdata registers 0, if_lost=0, wait counter 0.
REQ-036 After reset deasserts, the first access starts only from a new IDLE arbitration.

Structure
REQ-037 Shared package/header holds:
- State encodings.
- dm_size codes.
- Byte-enable constants.
- The MAX_WAIT default.
REQ-038 One sub-module, mem_lane_align: combinational byte-enable generation, write-data replication and misalign detection.

Verification
REQ-039 Single fetch: if_req, addr 0x100, mem_ack 2 cycles after mem_req, mem_rdata 0xDEADBEEF -> if_ready pulse with if_rdata 0xDEADBEEF, stall_if low the next cycle.
REQ-040 Contention: if_req and dm_req together -> DM served first, then IF; repeat with if_lost=1 -> IF served first.
REQ-041 Byte store: dm_size 00, addr 0x203, wdata 0x000000A5 -> mem_addr 0x200, mem_be 0001, mem_wdata 0xA5A5A5A5.
REQ-042 Misaligned word: addr 0x202 -> dm_ready and dm_err in one cycle, mem_req never asserted.
REQ-043 Timeout: no mem_ack for 16 cycles -> mem_req drops, dm_ready=1 with dm_err=1, dm_rdata 0.
REQ-044 Reset pulse in DM_BUSY, then a late mem_ack -> no ready pulse and state stays IDLE.
